// File: rtl/msx_io_pkg.sv
// Shared types and helpers for the MSX general-purpose port adapters.
// Provides the mouse nibble state type, the port pin width and the saturation functions.
package msx_io_pkg;

   localparam int unsigned MSX_PIN_W = 6;

   typedef enum logic [1:0] {S0, S1, S2, S3} mouse_nib_state_t;

   function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
      if (v > 32'sd127)
         return 8'sh7F;
      else if (v < -32'sd128)
         return 8'sh80;
      else
         return v[7:0];
   endfunction

   // Clamp v to the signed range of a w-bit two's complement value.
   function automatic logic signed [31:0] sat_acc(input logic signed [31:0] v,
                                                  input int unsigned w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/msx_mouse_ser.sv
// Per-port MSX mouse serialiser: delta accumulation, STR-clocked nibble FSM with timeout,
// and the registered output mux between mouse nibbles and joystick pass-through.
module msx_mouse_ser
   import msx_io_pkg::*;
#(
   parameter int unsigned ACC_W       = 12,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int unsigned TIMEOUT     = 100000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 act_set_i,
   input  logic                 act_clr_i,
   input  logic [8:0]           mouse_x_i,
   input  logic [8:0]           mouse_y_i,
   input  logic [1:0]           mouse_btn_i,
   input  logic [MSX_PIN_W-1:0] joy_n_i,
   input  logic                 str_i,
   output logic [MSX_PIN_W-1:0] port_n_o,
   output logic                 active_o
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   mouse_nib_state_t        state_q, state_d;
   logic                    active_q, active_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic signed [7:0]       snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [3:0]              nib_q, nib_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    str_d_q, edge_q;
   logic [MSX_PIN_W-1:0]    port_n_q, port_n_d;

   logic                    acc_en;
   logic signed [31:0]      ax, ay, dx, dy, sub_x, sub_y;
   logic signed [7:0]       sx, sy;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S0;
         active_q <= 1'b0;
         acc_x_q  <= '0;
         acc_y_q  <= '0;
         snap_x_q <= '0;
         snap_y_q <= '0;
         nib_q    <= 4'hF;
         tmo_q    <= '0;
         str_d_q  <= str_i;
         edge_q   <= 1'b0;
         port_n_q <= '1;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         acc_x_q  <= acc_x_d;
         acc_y_q  <= acc_y_d;
         snap_x_q <= snap_x_d;
         snap_y_q <= snap_y_d;
         nib_q    <= nib_d;
         tmo_q    <= tmo_d;
         str_d_q  <= str_i;
         edge_q   <= str_i ^ str_d_q;
         port_n_q <= port_n_d;
      end
   end

   always_comb begin
      active_d = active_q;
      if (act_set_i) active_d = 1'b1;
      if (act_clr_i) active_d = 1'b0;
      acc_en = act_set_i & ~act_clr_i;

      ax    = 32'(acc_x_q);
      ay    = 32'(acc_y_q);
      dx    = acc_en ? -(32'($signed(mouse_x_i))) : '0;
      dy    = acc_en ? 32'($signed(mouse_y_i)) : '0;
      sx    = '0;
      sy    = '0;
      sub_x = '0;
      sub_y = '0;

      state_d  = state_q;
      nib_d    = nib_q;
      snap_x_d = snap_x_q;
      snap_y_d = snap_y_q;
      tmo_d    = tmo_q;

      if (edge_q && active_q) begin
         tmo_d = TW'(TIMEOUT);
         unique case (state_q)
            S0: begin
               sx       = sat8(ax >>> SCALE_SHIFT);
               sy       = sat8(ay >>> SCALE_SHIFT);
               snap_x_d = sx;
               snap_y_d = sy;
               sub_x    = 32'(sx) <<< SCALE_SHIFT;
               sub_y    = 32'(sy) <<< SCALE_SHIFT;
               nib_d    = sx[7:4];
               state_d  = S1;
            end
            S1: begin
               nib_d   = snap_x_q[3:0];
               state_d = S2;
            end
            S2: begin
               nib_d   = snap_y_q[7:4];
               state_d = S3;
            end
            S3: begin
               nib_d   = snap_y_q[3:0];
               state_d = S0;
            end
         endcase
      end else if (tmo_q != '0) begin
         tmo_d = tmo_q - TW'(1);
         if (tmo_q == TW'(1)) state_d = S0;
      end

      // Snapshot removal and a coincident delta are folded into one saturating sum.
      acc_x_d = ACC_W'(sat_acc(ax - sub_x + dx, ACC_W));
      acc_y_d = ACC_W'(sat_acc(ay - sub_y + dy, ACC_W));

      if (!active_d) begin
         acc_x_d  = '0;
         acc_y_d  = '0;
         snap_x_d = '0;
         snap_y_d = '0;
         state_d  = S0;
         nib_d    = 4'hF;
         tmo_d    = '0;
      end

      port_n_d = active_d ? {~mouse_btn_i, nib_d} : (joy_n_i | {MSX_PIN_W{str_i}});
   end

   assign port_n_o = port_n_q;
   assign active_o = active_q;

endmodule

// File: rtl/msx_mouse_port_mux.sv
// MSX mouse/joystick port adapter: decodes the mouse target port and fans the
// packet out to one serialiser per general-purpose port.
module msx_mouse_port_mux
   import msx_io_pkg::*;
#(
   parameter int unsigned  NUM_PORTS   = 2,
   parameter int unsigned  ACC_W       = 12,
   parameter int unsigned  SCALE_SHIFT = 1,
   parameter int unsigned  TIMEOUT     = 100000,
   localparam int unsigned PSEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                           clk_sys,
   input  logic                           reset,
   input  logic [8:0]                     mouse_x,
   input  logic [8:0]                     mouse_y,
   input  logic [1:0]                     mouse_btn,
   input  logic                           mouse_strobe,
   input  logic [PSEL_W-1:0]              mouse_port,
   input  logic [MSX_PIN_W*NUM_PORTS-1:0] joy_n,
   input  logic [NUM_PORTS-1:0]           msx_str,
   output logic [MSX_PIN_W*NUM_PORTS-1:0] port_n,
   output logic [NUM_PORTS-1:0]           mouse_active
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic sel;
      logic joy_used;

      assign sel      = (mouse_port == PSEL_W'(p));
      assign joy_used = ~&joy_n[MSX_PIN_W*p +: MSX_PIN_W];

      msx_mouse_ser #(
         .ACC_W       (ACC_W),
         .SCALE_SHIFT (SCALE_SHIFT),
         .TIMEOUT     (TIMEOUT)
      ) u_ser (
         .clk_i       (clk_sys),
         .rst_i       (reset),
         .act_set_i   (mouse_strobe & sel),
         .act_clr_i   (~sel | joy_used),
         .mouse_x_i   (mouse_x),
         .mouse_y_i   (mouse_y),
         .mouse_btn_i (mouse_btn),
         .joy_n_i     (joy_n[MSX_PIN_W*p +: MSX_PIN_W]),
         .str_i       (msx_str[p]),
         .port_n_o    (port_n[MSX_PIN_W*p +: MSX_PIN_W]),
         .active_o    (mouse_active[p])
      );
   end

endmodule

// File: tb/tb_msx_mouse_port_mux.sv
// Directed bench for msx_mouse_port_mux with four ports and a short timeout.
module tb_msx_mouse_port_mux;

   localparam int NP  = 4;
   localparam int TMO = 40;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic [8:0]    mouse_x, mouse_y;
   logic [1:0]    mouse_btn;
   logic          mouse_strobe;
   logic [1:0]    mouse_port;
   logic [6*NP-1:0] joy_n;
   logic [NP-1:0] msx_str;
   logic [6*NP-1:0] port_n;
   logic [NP-1:0] mouse_active;

   int checks   = 0;
   int failures = 0;

   msx_mouse_port_mux #(
      .NUM_PORTS   (NP),
      .ACC_W       (12),
      .SCALE_SHIFT (1),
      .TIMEOUT     (TMO)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .mouse_btn    (mouse_btn),
      .mouse_strobe (mouse_strobe),
      .mouse_port   (mouse_port),
      .joy_n        (joy_n),
      .msx_str      (msx_str),
      .port_n       (port_n),
      .mouse_active (mouse_active)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int p, input int x, input int y);
      mouse_port   = 2'(p);
      mouse_x      = 9'(x);
      mouse_y      = 9'(y);
      mouse_strobe = 1'b1;
      tick();
      mouse_strobe = 1'b0;
      tick();
   endtask

   // One STR edge, then wait the two-clock latency and check the nibble pins.
   task automatic rd(input int p, input logic [31:0] exp, input string tag);
      msx_str[p] = ~msx_str[p];
      tick();
      tick();
      chk(tag, 32'(port_n[6*p +: 4]), exp);
   endtask

   initial begin
      reset        = 1'b1;
      joy_n        = '1;
      msx_str      = 4'b0101;
      mouse_strobe = 1'b0;
      mouse_port   = 2'd0;
      mouse_x      = '0;
      mouse_y      = '0;
      mouse_btn    = 2'b01;
      repeat (3) tick();
      reset = 1'b0;

      // 1: reset state
      tick();
      chk("rst_port_n", 32'(port_n), 32'h00FF_FFFF);
      chk("rst_active", 32'(mouse_active), 0);
      tick();
      chk("rst_port_n2", 32'(port_n), 32'h00FF_FFFF);

      // 2: x=-10, y=+6 -> snap 5,3
      strobe(0, -10, 6);
      chk("t2_active", 32'(mouse_active), 32'h1);
      chk("t2_idle_pins", 32'(port_n[5:0]), 32'h2F);
      rd(0, 'h0, "t2_n0");
      rd(0, 'h5, "t2_n1");
      rd(0, 'h0, "t2_n2");
      rd(0, 'h3, "t2_n3");
      rd(0, 'h0, "t2_res_n0");
      rd(0, 'h0, "t2_res_n1");
      rd(0, 'h0, "t2_res_n2");
      rd(0, 'h0, "t2_res_n3");

      // 3: 3 x (-100) -> 300, snap +127, residue 46, then 23
      strobe(0, -100, 0);
      strobe(0, -100, 0);
      strobe(0, -100, 0);
      rd(0, 'h7, "t3_sat_hi");
      rd(0, 'hF, "t3_sat_lo");
      rd(0, 'h0, "t3_y_hi");
      rd(0, 'h0, "t3_y_lo");
      rd(0, 'h1, "t3_res_hi");
      rd(0, 'h7, "t3_res_lo");
      rd(0, 'h0, "t3_res_y_hi");
      rd(0, 'h0, "t3_res_y_lo");

      // accumulator saturation: 9 x (-255) clamps at +2047 instead of wrapping
      for (int i = 0; i < 9; i++) strobe(0, -255, 0);
      rd(0, 'h7, "acc_sat_hi");
      rd(0, 'hF, "acc_sat_lo");
      rd(0, 'h0, "acc_sat_y_hi");
      rd(0, 'h0, "acc_sat_y_lo");
      // negative Y: y=-6 on top of remaining X residue is not needed; check via fresh mode later

      // 4: joystick takes over port 0
      joy_n[0]   = 1'b0;
      msx_str[0] = 1'b0;
      tick();
      chk("t4_active", 32'(mouse_active), 0);
      chk("t4_joy_str0", 32'(port_n[5:0]), 32'h3E);
      msx_str[0] = 1'b1;
      tick();
      chk("t4_joy_str1", 32'(port_n[5:0]), 32'h3F);
      msx_str[0] = 1'b0;
      joy_n[0]   = 1'b1;
      tick();
      chk("t4_release", 32'(port_n[5:0]), 32'h3F);
      chk("t4_still_joy", 32'(mouse_active), 0);

      // 5: timeout returns the FSM to S0; negative Y nibbles
      strobe(0, -10, -6);
      rd(0, 'h0, "t5_n0");
      rd(0, 'h5, "t5_n1");
      strobe(0, -64, 0);
      repeat (TMO) tick();
      rd(0, 'h2, "t5_fresh_hi");
      rd(0, 'h0, "t5_fresh_lo");
      rd(0, 'h0, "t5_fresh_y_hi");
      rd(0, 'h0, "t5_fresh_y_lo");

      // 6: port 3, strobe coincident with the S0 edge
      mouse_btn = 2'b10;
      strobe(3, -20, 0);
      chk("t6_active", 32'(mouse_active), 32'h8);
      chk("t6_others", 32'(port_n[17:0]), 32'h3FFFF);
      chk("t6_idle_pins", 32'(port_n[23:18]), 32'h1F);
      msx_str[3] = ~msx_str[3];
      tick();
      mouse_port   = 2'd3;
      mouse_x      = 9'(-6);
      mouse_y      = 9'(4);
      mouse_strobe = 1'b1;
      tick();
      mouse_strobe = 1'b0;
      chk("t6_co_hi", 32'(port_n[21:18]), 32'h0);
      rd(3, 'hA, "t6_co_lo");
      rd(3, 'h0, "t6_co_y_hi");
      rd(3, 'h0, "t6_co_y_lo");
      rd(3, 'h0, "t6_kept_hi");
      rd(3, 'h3, "t6_kept_lo");
      rd(3, 'h0, "t6_kept_y_hi");
      rd(3, 'h2, "t6_kept_y_lo");
      chk("t6_active_end", 32'(mouse_active), 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
